// File: rtl/e_1hot_mon_pkg.sv
// rtl/e_1hot_mon_pkg.sv - shared types and helper functions for the one-hot monitor
package e_1hot_mon_pkg;

    typedef enum logic {
        STRICT  = 1'b0,
        ZERO_OK = 1'b1
    } mode_e;

    function automatic mode_e mode_of(input int allow_zero);
        return (allow_zero != 0) ? ZERO_OK : STRICT;
    endfunction

    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Callers truncate the result back to cnt_w bits.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int cnt_w);
        logic [63:0] max_v;
        max_v = (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/e_1hot_chk.sv
// rtl/e_1hot_chk.sv - combinational legality check of one W-bit channel vector
module e_1hot_chk
    import e_1hot_mon_pkg::*;
#(
    parameter int W          = 8,
    parameter int ALLOW_ZERO = 0
) (
    input  logic [W-1:0] x,
    output logic         legal
);

    localparam mode_e MODE = mode_of(ALLOW_ZERO);

    logic at_most_one;
    logic any_set;

    // Clearing the lowest set bit leaves zero only if at most one bit was set.
    assign at_most_one = ((x & (x - W'(1))) == '0);
    assign any_set     = |x;
    assign legal       = at_most_one && ((MODE == ZERO_OK) || any_set);

endmodule

// File: rtl/e_1hot_mon.sv
// rtl/e_1hot_mon.sv - registered multi-channel one-hot monitor; E_1HOT_MON_FIRST_EN enables first-violation capture
module e_1hot_mon
    import e_1hot_mon_pkg::*;
#(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int ALLOW_ZERO = 0,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     i_vld,
    input  logic [N-1:0][W-1:0]      i_x,
    input  logic                     i_clr,
    output logic                     o_vld,
    output logic [N-1:0]             o_ok,
    output logic [N-1:0]             o_err,
    output logic                     o_err_any,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic                     o_first_vld,
    output logic [ch_idx_w(N)-1:0]   o_first_ch,
    output logic [W-1:0]             o_first_x
);

    localparam int CH_W = ch_idx_w(N);

    logic [N-1:0]     legal;
    logic [N-1:0]     viol;
    logic             bad;
    logic [N-1:0]     err_base;
    logic [CNT_W-1:0] cnt_base;

    for (genvar c = 0; c < N; c++) begin : g_chk
        e_1hot_chk #(
            .W          (W),
            .ALLOW_ZERO (ALLOW_ZERO)
        ) u_chk (
            .x     (i_x[c]),
            .legal (legal[c])
        );
    end

    assign viol = i_vld ? ~legal : '0;
    assign bad  = |viol;

    // Clear takes effect before the same-cycle violation is recorded.
    assign err_base = i_clr ? '0 : o_err;
    assign cnt_base = i_clr ? '0 : o_err_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            o_vld     <= 1'b0;
            o_ok      <= '0;
            o_err     <= '0;
            o_err_cnt <= '0;
        end else begin
            o_vld <= i_vld;
            if (i_vld) begin
                o_ok <= legal;
            end
            o_err <= err_base | viol;
            if (bad) begin
                o_err_cnt <= CNT_W'(sat_inc(64'(cnt_base), CNT_W));
            end else begin
                o_err_cnt <= cnt_base;
            end
        end
    end

    assign o_err_any = |o_err;

`ifdef E_1HOT_MON_FIRST_EN
    logic [CH_W-1:0] lo_ch;
    logic [W-1:0]    lo_x;

    // Descending scan so the lowest violating index wins.
    always_comb begin
        lo_ch = '0;
        lo_x  = '0;
        for (int c = N - 1; c >= 0; c--) begin
            if (viol[c]) begin
                lo_ch = CH_W'(c);
                lo_x  = i_x[c];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            o_first_vld <= 1'b0;
            o_first_ch  <= '0;
            o_first_x   <= '0;
        end else if (bad && (i_clr || !o_first_vld)) begin
            o_first_vld <= 1'b1;
            o_first_ch  <= lo_ch;
            o_first_x   <= lo_x;
        end else if (i_clr) begin
            o_first_vld <= 1'b0;
            o_first_ch  <= '0;
            o_first_x   <= '0;
        end
    end
`else
    assign o_first_vld = 1'b0;
    assign o_first_ch  = '0;
    assign o_first_x   = '0;
`endif

endmodule

// File: tb/tb_e_1hot_mon.sv
// tb/tb_e_1hot_mon.sv - scoreboard bench for e_1hot_mon (strict, zero-ok and W=1 instances)
module tb_e_1hot_mon;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic               i_vld, i_clr;
    logic [N-1:0][W-1:0] i_x;
    logic               o_vld, o_err_any, o_first_vld;
    logic [N-1:0]       o_ok, o_err;
    logic [CNT_W-1:0]   o_err_cnt;
    logic [1:0]         o_first_ch;
    logic [W-1:0]       o_first_x;

    e_1hot_mon #(.N(N), .W(W), .ALLOW_ZERO(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst), .i_vld(i_vld), .i_x(i_x), .i_clr(i_clr),
        .o_vld(o_vld), .o_ok(o_ok), .o_err(o_err), .o_err_any(o_err_any),
        .o_err_cnt(o_err_cnt), .o_first_vld(o_first_vld),
        .o_first_ch(o_first_ch), .o_first_x(o_first_x)
    );

    logic               z_vld, z_clr, zo_vld, zo_err_any, zo_first_vld;
    logic [N-1:0][W-1:0] z_x;
    logic [N-1:0]       zo_ok, zo_err;
    logic [CNT_W-1:0]   zo_err_cnt;
    logic [1:0]         zo_first_ch;
    logic [W-1:0]       zo_first_x;

    e_1hot_mon #(.N(N), .W(W), .ALLOW_ZERO(1), .CNT_W(CNT_W)) dut_z (
        .clk(clk), .arst(arst), .i_vld(z_vld), .i_x(z_x), .i_clr(z_clr),
        .o_vld(zo_vld), .o_ok(zo_ok), .o_err(zo_err), .o_err_any(zo_err_any),
        .o_err_cnt(zo_err_cnt), .o_first_vld(zo_first_vld),
        .o_first_ch(zo_first_ch), .o_first_x(zo_first_x)
    );

    logic           w_vld, w_clr, wo_vld, wo_err_any, wo_first_vld;
    logic [1:0][0:0] w_x;
    logic [1:0]     wo_ok, wo_err;
    logic [CNT_W-1:0] wo_err_cnt;
    logic [0:0]     wo_first_ch;
    logic [0:0]     wo_first_x;

    e_1hot_mon #(.N(2), .W(1), .ALLOW_ZERO(0), .CNT_W(CNT_W)) dut_w1 (
        .clk(clk), .arst(arst), .i_vld(w_vld), .i_x(w_x), .i_clr(w_clr),
        .o_vld(wo_vld), .o_ok(wo_ok), .o_err(wo_err), .o_err_any(wo_err_any),
        .o_err_cnt(wo_err_cnt), .o_first_vld(wo_first_vld),
        .o_first_ch(wo_first_ch), .o_first_x(wo_first_x)
    );

    typedef struct {
        logic         vld;
        logic [N-1:0] ok;
        logic [N-1:0] err;
        logic [3:0]   cnt;
        logic         fv;
        logic [1:0]   fc;
        logic [7:0]   fx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    logic [N-1:0] m_ok, m_err;
    logic [3:0]   m_cnt;
    logic         m_fv;
    logic [1:0]   m_fc;
    logic [7:0]   m_fx;

    function automatic logic is_one_hot(input logic [7:0] v);
        return ($countones(v) == 1);
    endfunction

    task automatic model_reset();
        m_ok = '0; m_err = '0; m_cnt = '0; m_fv = 1'b0; m_fc = '0; m_fx = '0;
        sb.delete();
    endtask

    task automatic drive(input logic vld, input logic clr, input logic [N-1:0][W-1:0] x);
        exp_t e;
        logic [N-1:0] v;
        i_vld = vld; i_clr = clr; i_x = x;
        if (clr) begin
            m_err = '0; m_cnt = '0; m_fv = 1'b0; m_fc = '0; m_fx = '0;
        end
        v = '0;
        if (vld) begin
            for (int c = 0; c < N; c++) v[c] = !is_one_hot(x[c]);
            m_ok = ~v;
        end
        m_err = m_err | v;
        if (v != '0) begin
            if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            if (!m_fv) begin
                m_fv = 1'b1;
                for (int c = N - 1; c >= 0; c--) begin
                    if (v[c]) begin
                        m_fc = 2'(c);
                        m_fx = x[c];
                    end
                end
            end
        end
        e.vld = vld; e.ok = m_ok; e.err = m_err; e.cnt = m_cnt;
`ifdef E_1HOT_MON_FIRST_EN
        e.fv = m_fv; e.fc = m_fc; e.fx = m_fx;
`else
        e.fv = 1'b0; e.fc = '0; e.fx = '0;
`endif
        sb.push_back(e);
        @(negedge clk);
        i_vld = 1'b0; i_clr = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (o_vld !== mon_e.vld) begin errors++; $display("FAIL sb_vld: got %b expected %b", o_vld, mon_e.vld); end
            checks++;
            if (o_ok !== mon_e.ok) begin errors++; $display("FAIL sb_ok: got %b expected %b", o_ok, mon_e.ok); end
            checks++;
            if (o_err !== mon_e.err) begin errors++; $display("FAIL sb_err: got %b expected %b", o_err, mon_e.err); end
            checks++;
            if (o_err_any !== (|mon_e.err)) begin errors++; $display("FAIL sb_err_any: got %b expected %b", o_err_any, |mon_e.err); end
            checks++;
            if (o_err_cnt !== mon_e.cnt) begin errors++; $display("FAIL sb_cnt: got %h expected %h", o_err_cnt, mon_e.cnt); end
            checks++;
            if ({o_first_vld, o_first_ch, o_first_x} !== {mon_e.fv, mon_e.fc, mon_e.fx}) begin
                errors++;
                $display("FAIL sb_first: got %b/%0d/%h expected %b/%0d/%h",
                         o_first_vld, o_first_ch, o_first_x, mon_e.fv, mon_e.fc, mon_e.fx);
            end
        end
    end

    task automatic test_reset();
        arst = 1'b1;
        i_vld = 1'b0; i_clr = 1'b0; i_x = '0;
        z_vld = 1'b0; z_clr = 1'b0; z_x = '0;
        w_vld = 1'b0; w_clr = 1'b0; w_x = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({o_vld, o_ok, o_err, o_err_any, o_err_cnt} !== '0) begin
            errors++; $display("FAIL reset_main: got %b expected 0", {o_vld, o_ok, o_err, o_err_any, o_err_cnt});
        end
        checks++;
        if ({o_first_vld, o_first_ch, o_first_x} !== '0) begin
            errors++; $display("FAIL reset_first: got %b expected 0", {o_first_vld, o_first_ch, o_first_x});
        end
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_legal();
        drive(1'b1, 1'b0, {8'h01, 8'h80, 8'h10, 8'h02});
        checks++;
        if (o_ok !== 4'hF || o_err_cnt !== 4'h0) begin
            errors++; $display("FAIL all_legal: got ok=%h cnt=%h expected ok=f cnt=0", o_ok, o_err_cnt);
        end
    endtask

    task automatic test_multi_hot();
        drive(1'b1, 1'b0, {8'h01, 8'h00, 8'h03, 8'h02});
        checks++;
        if (o_ok !== 4'b1001 || o_err !== 4'b0110 || o_err_cnt !== 4'h1) begin
            errors++; $display("FAIL multi_hot: got ok=%b err=%b cnt=%h expected 1001/0110/1", o_ok, o_err, o_err_cnt);
        end
`ifdef E_1HOT_MON_FIRST_EN
        checks++;
        if (o_first_ch !== 2'd1 || o_first_x !== 8'h03) begin
            errors++; $display("FAIL multi_hot_first: got ch=%0d x=%h expected 1/03", o_first_ch, o_first_x);
        end
`endif
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, {8'h01, 8'h80, 8'h10, 8'hFF});
        checks++;
        if (o_err_cnt !== 4'hF) begin
            errors++; $display("FAIL saturation: got %h expected f", o_err_cnt);
        end
        drive(1'b1, 1'b1, {8'h01, 8'h80, 8'h10, 8'h02});
        checks++;
        if (o_err !== 4'h0 || o_err_cnt !== 4'h0) begin
            errors++; $display("FAIL clr_legal: got err=%b cnt=%h expected 0/0", o_err, o_err_cnt);
        end
    endtask

    task automatic test_clr_coincident();
        drive(1'b1, 1'b0, {8'h01, 8'h80, 8'h10, 8'h00});
        drive(1'b1, 1'b1, {8'hFF, 8'h80, 8'h10, 8'h02});
        checks++;
        if (o_err !== 4'b1000 || o_err_cnt !== 4'h1) begin
            errors++; $display("FAIL clr_coincident: got err=%b cnt=%h expected 1000/1", o_err, o_err_cnt);
        end
`ifdef E_1HOT_MON_FIRST_EN
        checks++;
        if (o_first_vld !== 1'b1 || o_first_ch !== 2'd3 || o_first_x !== 8'hFF) begin
            errors++; $display("FAIL clr_coincident_first: got %b/%0d/%h expected 1/3/ff", o_first_vld, o_first_ch, o_first_x);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [N-1:0][W-1:0] x;
        for (int i = 0; i < 60; i++) begin
            for (int c = 0; c < N; c++) begin
                case ($urandom_range(3))
                    0, 1: x[c] = 8'(1 << $urandom_range(7));
                    2:    x[c] = 8'h00;
                    default: x[c] = 8'($urandom);
                endcase
            end
            drive($urandom_range(3) != 0, $urandom_range(15) == 0, x);
        end
    endtask

    task automatic test_allow_zero();
        z_vld = 1'b1; z_x = '0;
        @(negedge clk);
        checks++;
        if (zo_vld !== 1'b1 || zo_ok !== 4'hF || zo_err_cnt !== 4'h0) begin
            errors++; $display("FAIL zero_ok_all_zero: got vld=%b ok=%h cnt=%h expected 1/f/0", zo_vld, zo_ok, zo_err_cnt);
        end
        z_x = {8'h01, 8'h02, 8'h00, 8'h81};
        @(negedge clk);
        z_vld = 1'b0;
        checks++;
        if (zo_ok !== 4'b1110 || zo_err !== 4'b0001 || zo_err_cnt !== 4'h1) begin
            errors++; $display("FAIL zero_ok_multi: got ok=%b err=%b cnt=%h expected 1110/0001/1", zo_ok, zo_err, zo_err_cnt);
        end
    endtask

    task automatic test_w1();
        w_vld = 1'b1; w_x = {1'b1, 1'b0};
        @(negedge clk);
        w_vld = 1'b0;
        checks++;
        if (wo_ok !== 2'b10 || wo_err !== 2'b01 || wo_err_cnt !== 4'h1) begin
            errors++; $display("FAIL w1_strict: got ok=%b err=%b cnt=%h expected 10/01/1", wo_ok, wo_err, wo_err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, {8'h01, 8'h80, 8'h00, 8'h02});
        i_vld = 1'b1; i_x = {8'h03, 8'h80, 8'h10, 8'h02};
        #2 arst = 1'b1;
        #1;
        checks++;
        if ({o_vld, o_ok, o_err, o_err_any, o_err_cnt, o_first_vld, o_first_ch, o_first_x} !== '0) begin
            errors++; $display("FAIL reset_async: got %b expected 0", {o_vld, o_ok, o_err, o_err_cnt});
        end
        @(negedge clk);
        arst = 1'b0; i_vld = 1'b0; i_x = '0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({o_vld, o_ok, o_err, o_err_any, o_err_cnt, o_first_vld, o_first_ch, o_first_x} !== '0) begin
            errors++; $display("FAIL reset_mid_stale: got %b expected 0", {o_vld, o_ok, o_err, o_err_cnt});
        end
    endtask

    initial begin
        test_reset();
        test_all_legal();
        test_multi_hot();
        test_saturation();
        test_clr_coincident();
        test_back_to_back();
        test_allow_zero();
        test_w1();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
